// File: rtl/multi_ch_data_sync_pkg.sv
// Shared definitions for the multi-channel data synchronizer.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package data_sync_pkg;

    // Enable interpretation: level rise vs. per-word toggle handshake
    localparam int EN_MODE_RISE   = 0;
    localparam int EN_MODE_TOGGLE = 1;

    // Channel index width; a single channel still gets a 1-bit index port
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_ch_data_sync_bit.sv
// Multi-flop synchronizer for one asynchronous enable bit.
// Latency: NUM_Stages destination clock edges.
// Backpressure: none, free-running.
module bit_sync #(
    parameter int NUM_Stages = 2
) (
    input  logic CLK,
    input  logic Reset,
    input  logic i_d,
    output logic o_q
);

    logic [NUM_Stages-1:0] r_sync;

    // Shift the asynchronous bit through the flop chain
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[NUM_Stages-2:0], i_d};
        end
    end

    assign o_q = r_sync[NUM_Stages-1];

endmodule

// File: rtl/multi_ch_data_sync.sv
// Captures per-channel async data on synchronized enables, round-robin presents to one consumer.
// Latency: NUM_Stages+1 edges from bus_EN transition to EN_pulse/out_valid.
// Backpressure: one holding slot per channel; an event on a full, unaccepted slot drops data and flags overrun.
module multi_ch_data_sync
    import data_sync_pkg::*;
#(
    parameter int NUM_Stages = 2,
    parameter int Width      = 8,
    parameter int NUM_CH     = 4,
    parameter int EN_MODE    = EN_MODE_RISE
) (
    input  logic                          CLK,
    input  logic                          Reset,
    input  logic [NUM_CH*Width-1:0]       Async_bus,
    input  logic [NUM_CH-1:0]             bus_EN,
    input  logic [NUM_CH-1:0]             clr_ovr,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [Width-1:0]              sync_bus,
    output logic [ch_idx_w(NUM_CH)-1:0]   out_ch,
    output logic [NUM_CH-1:0]             EN_pulse,
    output logic [NUM_CH-1:0]             ack_tgl,
    output logic [NUM_CH-1:0]             overrun
);

    localparam int             CW      = ch_idx_w(NUM_CH);
    localparam logic [CW-1:0]  PTR_RST = CW'(NUM_CH - 1);

    logic [NUM_CH-1:0] w_sync;
    logic [NUM_CH-1:0] w_evt;
    logic [NUM_CH-1:0] w_acc_vec;
    logic [NUM_CH-1:0] w_capture;
    logic [NUM_CH-1:0] w_drop;
    logic [CW-1:0]     w_grant;
    logic              w_accept;

    logic [NUM_CH-1:0] r_hist;
    logic [NUM_CH-1:0] r_hold_vld;
    logic [NUM_CH-1:0] r_en_pulse;
    logic [NUM_CH-1:0] r_ack;
    logic [NUM_CH-1:0] r_ovr;
    logic [CW-1:0]     r_ptr;
    logic [Width-1:0]  r_hold_data [NUM_CH];

    // Round-robin pick: nearest valid channel after ptr, wrapping; descending
    // scan so the last hit is the closest one in rotation order.
    function automatic logic [CW-1:0] rr_pick(input logic [NUM_CH-1:0] vld,
                                              input logic [CW-1:0]     ptr);
        logic [CW-1:0] pick;
        int            idx;
        pick = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = (int'(ptr) + i) % NUM_CH;
            if (vld[idx[CW-1:0]]) begin
                pick = idx[CW-1:0];
            end
        end
        return pick;
    endfunction

    genvar gc;
    generate
        for (gc = 0; gc < NUM_CH; gc++) begin : g_sync
            bit_sync #(.NUM_Stages(NUM_Stages)) u_bit_sync (
                .CLK   (CLK),
                .Reset (Reset),
                .i_d   (bus_EN[gc]),
                .o_q   (w_sync[gc])
            );
        end

        if (EN_MODE == EN_MODE_TOGGLE) begin : g_evt_tgl
            assign w_evt = w_sync ^ r_hist;
        end else begin : g_evt_rise
            assign w_evt = w_sync & ~r_hist;
        end
    endgenerate

    assign w_grant   = rr_pick(r_hold_vld, r_ptr);
    assign out_valid = |r_hold_vld;
    assign w_accept  = out_valid & out_ready;
    assign sync_bus  = r_hold_data[w_grant];
    assign out_ch    = w_grant;
    assign EN_pulse  = r_en_pulse;
    assign ack_tgl   = r_ack;
    assign overrun   = r_ovr;

    // Decode the accepted channel; an event in its accept cycle may refill the slot
    always_comb begin
        w_acc_vec = '0;
        if (w_accept) begin
            w_acc_vec[w_grant] = 1'b1;
        end
    end

    assign w_capture = w_evt & (~r_hold_vld | w_acc_vec);
    assign w_drop    = w_evt & r_hold_vld & ~w_acc_vec;

    // Per-channel control: history, slot occupancy, capture pulse, ack toggle, sticky overrun
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_hist     <= '0;
            r_hold_vld <= '0;
            r_en_pulse <= '0;
            r_ack      <= '0;
            r_ovr      <= '0;
        end else begin
            r_hist     <= w_sync;
            r_hold_vld <= (r_hold_vld & ~w_acc_vec) | w_capture;
            r_en_pulse <= w_capture;
            r_ack      <= r_ack ^ w_acc_vec;
            r_ovr      <= w_drop | (r_ovr & ~clr_ovr);
        end
    end

    // Latch each channel's source word when its slot accepts the event
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_hold_data[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_capture[c]) begin
                    r_hold_data[c] <= Async_bus[c*Width +: Width];
                end
            end
        end
    end

    // Rotation pointer follows the last accepted channel; reset value makes channel 0 first
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_ptr <= PTR_RST;
        end else if (w_accept) begin
            r_ptr <= w_grant;
        end
    end

endmodule
